smg_scan4: RTL and testbench

SMG_SCAN4 -- requirements
Module: smg_scan4

---
 rtl/smg_scan4_pkg.sv | 20 ++
 rtl/smg_scan4_if.sv | 20 ++
 rtl/smg_scan4_hex_to_smg.sv | 12 +
 rtl/smg_scan4.sv | 138 +++++++++++++
 tb/tb_smg_scan4.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/smg_scan4_pkg.sv
// Shared types and constants for the 4-digit seven-segment scanner.
package smg_scan4_pkg;

  // Blank pattern for the whole digit, dp included (active-low).
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low segments g..a for hex digits 0..F; dp is handled separately.
  localparam logic [6:0] SEG_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } scan_state_e;

endpackage

// File: rtl/smg_scan4_if.sv
// Host-side bus of the scanner: shadow-register load path and display pins.
interface smg_scan4_if;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp;
  logic        blank_lz;
  logic        load_ack;
  logic [7:0]  dataout;
  logic [3:0]  led_bit;

  modport master (
    output value, load, dp, blank_lz,
    input  load_ack, dataout, led_bit
  );

  modport slave (
    input  value, load, dp, blank_lz,
    output load_ack, dataout, led_bit
  );
endinterface

// File: rtl/smg_scan4_hex_to_smg.sv
// Hex nibble to active-low seven-segment pattern (g..a), purely combinational.
module hex_to_smg
  import smg_scan4_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg_c
);

  // Table lookup.
  assign seg_c = SEG_TAB[hex];

endmodule

// File: rtl/smg_scan4.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
module smg_scan4
  import smg_scan4_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 500
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  smg_scan4_if.slave bus
);

  localparam int unsigned CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);

  logic [CNT_W-1:0] cnt_q, cnt_n;
  scan_state_e      state_q, state_n;
  logic             wrap_c;

  logic [15:0] val_q;
  logic [3:0]  dp_q;
  logic        blz_q;
  logic        load_ack_q;

  logic [3:0]  nib_c;
  logic        dp_bit_c;
  logic        blank_c;
  logic [3:0]  dig_c;
  logic [6:0]  dec_seg_c;
  logic [7:0]  snap_q, snap_n;
  logic [7:0]  dataout_q;
  logic [3:0]  led_bit_q;

  // Shadow register and load acknowledge; the last load of a burst wins.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      val_q      <= '0;
      dp_q       <= '0;
      blz_q      <= 1'b0;
      load_ack_q <= 1'b0;
    end else begin
      load_ack_q <= bus.load;
      if (bus.load) begin
        val_q <= bus.value;
        dp_q  <= bus.dp;
        blz_q <= bus.blank_lz;
      end
    end
  end

  // Prescaler and scan state register.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      state_q <= DIG0;
    end else begin
      cnt_q   <= cnt_n;
      state_q <= state_n;
    end
  end

  // Next prescaler value and next digit; the digit only moves on a prescaler wrap.
  always_comb begin
    wrap_c  = (cnt_q == CNT_LAST);
    cnt_n   = wrap_c ? '0 : cnt_q + CNT_W'(1);
    state_n = state_q;
    if (wrap_c) begin
      case (state_q)
        DIG0:    state_n = DIG1;
        DIG1:    state_n = DIG2;
        DIG2:    state_n = DIG3;
        DIG3:    state_n = DIG0;
        default: state_n = DIG0;
      endcase
    end
  end

  // Select the upcoming digit's nibble, dp, leading-zero blank and anode.
  always_comb begin
    nib_c    = val_q[3:0];
    dp_bit_c = dp_q[0];
    blank_c  = 1'b0;
    dig_c    = 4'b1110;
    case (state_n)
      DIG1: begin
        nib_c    = val_q[7:4];
        dp_bit_c = dp_q[1];
        blank_c  = blz_q && (val_q[15:4] == 12'h000);
        dig_c    = 4'b1101;
      end
      DIG2: begin
        nib_c    = val_q[11:8];
        dp_bit_c = dp_q[2];
        blank_c  = blz_q && (val_q[15:8] == 8'h00);
        dig_c    = 4'b1011;
      end
      DIG3: begin
        nib_c    = val_q[15:12];
        dp_bit_c = dp_q[3];
        blank_c  = blz_q && (val_q[15:12] == 4'h0);
        dig_c    = 4'b0111;
      end
      default: ;
    endcase
  end

  hex_to_smg u_hex_to_smg (
    .hex   (nib_c),
    .seg_c (dec_seg_c)
  );

  // Snapshot is frozen for the whole slot so mid-slot loads never tear a digit.
  assign snap_n = wrap_c ? {~dp_bit_c, (blank_c ? 7'h7F : dec_seg_c)} : snap_q;

  // Registered pins, aligned with the prescaler value they belong to.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      snap_q    <= {1'b1, SEG_TAB[0]};
      dataout_q <= SEG_OFF;
      led_bit_q <= 4'hF;
    end else begin
      snap_q <= snap_n;
      if (cnt_n < CNT_BLANK) begin
        dataout_q <= SEG_OFF;
        led_bit_q <= 4'hF;
      end else begin
        dataout_q <= snap_n;
        led_bit_q <= dig_c;
      end
    end
  end

  assign bus.dataout  = dataout_q;
  assign bus.led_bit  = led_bit_q;
  assign bus.load_ack = load_ack_q;

endmodule

// File: tb/tb_smg_scan4.sv
// Directed bench for smg_scan4 with SCAN_DIV=8, BLANK_CYC=2.
module tb_smg_scan4;

  localparam int unsigned SCAN_DIV  = 8;
  localparam int unsigned BLANK_CYC = 2;

  logic clk_50M;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc;

  smg_scan4_if bus ();

  smg_scan4 #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_dut (
    .clk_50M (clk_50M),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  initial clk_50M = 1'b0;
  always #5 clk_50M = ~clk_50M;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance one clock; return at the falling edge so outputs are stable.
  task automatic step();
    @(posedge clk_50M);
    cyc++;
    @(negedge clk_50M);
  endtask

  // Check both pins for the current prescaler phase and digit.
  task automatic chk_phase(input logic [7:0] seg_exp);
    int c;
    int d;
    logic [3:0] led_exp;
    logic [7:0] dat_exp;
    c = cyc % int'(SCAN_DIV);
    d = (cyc / int'(SCAN_DIV)) % 4;
    if (c < int'(BLANK_CYC)) begin
      led_exp = 4'hF;
      dat_exp = 8'hFF;
    end else begin
      led_exp = 4'hF;
      led_exp[d] = 1'b0;
      dat_exp = seg_exp;
    end
    chk($sformatf("led d%0d c%0d", d, c), 32'(bus.led_bit), 32'(led_exp));
    chk($sformatf("dataout d%0d c%0d", d, c), 32'(bus.dataout), 32'(dat_exp));
  endtask

  // Align to the next DIG0 slot start, then check one full scan frame.
  task automatic run_digits(input logic [31:0] exp);
    while ((cyc % 32) != 0) step();
    for (int i = 0; i < 32; i++) begin
      chk_phase(exp[8*((cyc / 8) % 4) +: 8]);
      step();
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic b);
    bus.value    = v;
    bus.dp       = d;
    bus.blank_lz = b;
    bus.load     = 1'b1;
    step();
    chk("load_ack pulse", 32'(bus.load_ack), 32'd1);
    bus.load = 1'b0;
    step();
    chk("load_ack drop", 32'(bus.load_ack), 32'd0);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    cyc          = 0;
    rst_n        = 1'b0;
    bus.value    = 16'h0000;
    bus.load     = 1'b0;
    bus.dp       = 4'h0;
    bus.blank_lz = 1'b0;

    // Reset values.
    repeat (3) @(negedge clk_50M);
    chk("rst dataout", 32'(bus.dataout), 32'hFF);
    chk("rst led_bit", 32'(bus.led_bit), 32'hF);
    chk("rst load_ack", 32'(bus.load_ack), 32'd0);
    rst_n = 1'b1;
    cyc   = 0;

    // No load: all digits show 0, leading zeros visible.
    run_digits({8'hC0, 8'hC0, 8'hC0, 8'hC0});

    // 12AF with dp on digit 2.
    do_load(16'h12AF, 4'b0100, 1'b0);
    run_digits({8'hF9, 8'h24, 8'h88, 8'h8E});

    // Leading-zero blanking, then dp survives blanking on digit 3.
    do_load(16'h0005, 4'b0000, 1'b1);
    run_digits({8'hFF, 8'hFF, 8'hFF, 8'h92});
    do_load(16'h0005, 4'b1000, 1'b1);
    run_digits({8'h7F, 8'hFF, 8'hFF, 8'h92});

    // Load late in DIG1: DIG1 keeps old nibble, DIG2 onward shows new data.
    do_load(16'h3456, 4'b0000, 1'b0);
    run_digits({8'hB0, 8'h99, 8'h92, 8'h82});
    while ((cyc % 32) != 13) step();
    chk_phase(8'h92);
    bus.value = 16'h789A;
    bus.load  = 1'b1;
    step();
    bus.load  = 1'b0;
    while ((cyc % 32) != 0) begin
      case ((cyc / 8) % 4)
        1:       chk_phase(8'h92);
        2:       chk_phase(8'h80);
        default: chk_phase(8'hF8);
      endcase
      step();
    end
    run_digits({8'hF8, 8'h80, 8'h90, 8'h88});

    // Asynchronous reset in the middle of DIG2's lit phase.
    while ((cyc % 32) != 20) step();
    chk("pre-rst dataout", 32'(bus.dataout), 32'h80);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst dataout", 32'(bus.dataout), 32'hFF);
    chk("async rst led_bit", 32'(bus.led_bit), 32'hF);
    repeat (2) @(negedge clk_50M);
    rst_n = 1'b1;
    cyc   = 0;
    run_digits({8'hC0, 8'hC0, 8'hC0, 8'hC0});

    // Back-to-back loads: last wins, ack high on two consecutive cycles.
    bus.dp       = 4'h0;
    bus.blank_lz = 1'b0;
    bus.value    = 16'h1111;
    bus.load     = 1'b1;
    step();
    chk("b2b ack 1", 32'(bus.load_ack), 32'd1);
    bus.value = 16'h2222;
    step();
    chk("b2b ack 2", 32'(bus.load_ack), 32'd1);
    bus.load = 1'b0;
    step();
    chk("b2b ack end", 32'(bus.load_ack), 32'd0);
    run_digits({8'hA4, 8'hA4, 8'hA4, 8'hA4});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
